// File: rtl/arf_commit_scheduler.sv
// In-order commit queue between ROB retire and a 128-entry ARF, with operand-read forwarding.
// Latency: retire -> arf_write_en >= 2 cycles; read request -> rd_resp_valid exactly 1 cycle.
// Backpressure: ret_ready drops when fewer than 3 queue entries are free; reads are never stalled.
//
// Ports:
//   clk, rstn                     clock, synchronous active-low reset
//   ret_valid/ret_addrN/ret_dataN retire group (bit0 = slot1, oldest); ret_ready accepts a group
//   rd_req_valid/rd_addr1/2       operand read request; rd_resp_valid/rd_data1/2 one cycle later
//   arf_write_*                   3 ARF write ports sharing one enable
//   arf_read_*                    2 ARF read ports (read data returns in the request cycle)
//   pending_cnt, idle             queue occupancy; queue and write stage both empty
module arf_commit_scheduler #(
  parameter int AR_SIZE = 7,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [2:0]                ret_valid,
  input  logic [AR_SIZE-1:0]        ret_addr1,
  input  logic [AR_SIZE-1:0]        ret_addr2,
  input  logic [AR_SIZE-1:0]        ret_addr3,
  input  logic [DATA_W-1:0]         ret_data1,
  input  logic [DATA_W-1:0]         ret_data2,
  input  logic [DATA_W-1:0]         ret_data3,
  output logic                      ret_ready,
  input  logic                      rd_req_valid,
  input  logic [AR_SIZE-1:0]        rd_addr1,
  input  logic [AR_SIZE-1:0]        rd_addr2,
  output logic                      rd_resp_valid,
  output logic [DATA_W-1:0]         rd_data1,
  output logic [DATA_W-1:0]         rd_data2,
  output logic [AR_SIZE-1:0]        arf_write_addr1,
  output logic [AR_SIZE-1:0]        arf_write_addr2,
  output logic [AR_SIZE-1:0]        arf_write_addr3,
  output logic [DATA_W-1:0]         arf_write_data1,
  output logic [DATA_W-1:0]         arf_write_data2,
  output logic [DATA_W-1:0]         arf_write_data3,
  output logic                      arf_write_en,
  output logic [AR_SIZE-1:0]        arf_read_addr1,
  output logic [AR_SIZE-1:0]        arf_read_addr2,
  output logic                      arf_read_en,
  input  logic [DATA_W-1:0]         arf_read_data1,
  input  logic [DATA_W-1:0]         arf_read_data2,
  output logic [$clog2(DEPTH):0]    pending_cnt,
  output logic                      idle
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Queue storage and pointers
  logic [AR_SIZE-1:0] r_q_addr [DEPTH];
  logic [DATA_W-1:0]  r_q_data [DEPTH];
  logic [PW-1:0]      r_head;
  logic [PW-1:0]      r_tail;
  logic [CW-1:0]      r_cnt;

  // Write stage (drives the ARF write ports)
  logic               r_wen;
  logic [AR_SIZE-1:0] r_waddr [3];
  logic [DATA_W-1:0]  r_wdata [3];

  // Registered read response
  logic               r_rd_vld;
  logic [DATA_W-1:0]  r_rd_data [2];

  logic [AR_SIZE-1:0] w_ret_addr [3];
  logic [DATA_W-1:0]  w_ret_data [3];
  logic [2:0]         w_ret_keep;
  logic               w_ret_rdy;
  logic [1:0]         w_enq_off [3];
  logic [1:0]         w_enq_cnt;
  logic [1:0]         w_enq;
  logic [PW-1:0]      w_hidx [3];
  logic [2:0]         w_sel;
  logic [1:0]         w_k;
  logic [AR_SIZE-1:0] w_nxt_addr [3];
  logic [DATA_W-1:0]  w_nxt_data [3];
  logic [AR_SIZE-1:0] w_rd_addr [2];
  logic [DATA_W-1:0]  w_arf_rd [2];
  logic [DATA_W-1:0]  w_fwd [2];

  assign w_ret_addr[0] = ret_addr1;
  assign w_ret_addr[1] = ret_addr2;
  assign w_ret_addr[2] = ret_addr3;
  assign w_ret_data[0] = ret_data1;
  assign w_ret_data[1] = ret_data2;
  assign w_ret_data[2] = ret_data3;
  assign w_rd_addr[0]  = rd_addr1;
  assign w_rd_addr[1]  = rd_addr2;
  assign w_arf_rd[0]   = arf_read_data1;
  assign w_arf_rd[1]   = arf_read_data2;

  // Writes to r0 are architecturally meaningless, so they never occupy a queue slot.
  assign w_ret_keep[0] = ret_valid[0] && (ret_addr1 != '0);
  assign w_ret_keep[1] = ret_valid[1] && (ret_addr2 != '0);
  assign w_ret_keep[2] = ret_valid[2] && (ret_addr3 != '0);

  assign w_ret_rdy = (CW'(DEPTH) - r_cnt) >= CW'(3);

  // Compaction: each kept slot lands at tail + (number of kept older slots).
  always_comb begin
    w_enq_cnt = '0;
    for (int i = 0; i < 3; i++) begin
      w_enq_off[i] = w_enq_cnt;
      if (w_ret_keep[i]) w_enq_cnt = w_enq_cnt + 2'd1;
    end
  end

  assign w_enq = w_ret_rdy ? w_enq_cnt : 2'd0;

  // Drain group: up to 3 oldest entries, cut before the first address repeat so
  // the shared-enable write ports never carry two values for one register.
  always_comb begin
    for (int i = 0; i < 3; i++) w_hidx[i] = r_head + PW'(i);
    w_sel[0] = (r_cnt != '0);
    w_sel[1] = w_sel[0] && (r_cnt >= CW'(2)) &&
               (r_q_addr[w_hidx[1]] != r_q_addr[w_hidx[0]]);
    w_sel[2] = w_sel[1] && (r_cnt >= CW'(3)) &&
               (r_q_addr[w_hidx[2]] != r_q_addr[w_hidx[0]]) &&
               (r_q_addr[w_hidx[2]] != r_q_addr[w_hidx[1]]);
    w_k = {1'b0, w_sel[0]} + {1'b0, w_sel[1]} + {1'b0, w_sel[2]};
    // Unused ports repeat the last selected entry; a repeated write is harmless.
    w_nxt_addr[0] = w_sel[0] ? r_q_addr[w_hidx[0]] : '0;
    w_nxt_data[0] = w_sel[0] ? r_q_data[w_hidx[0]] : '0;
    w_nxt_addr[1] = w_sel[1] ? r_q_addr[w_hidx[1]] : w_nxt_addr[0];
    w_nxt_data[1] = w_sel[1] ? r_q_data[w_hidx[1]] : w_nxt_data[0];
    w_nxt_addr[2] = w_sel[2] ? r_q_addr[w_hidx[2]] : w_nxt_addr[1];
    w_nxt_data[2] = w_sel[2] ? r_q_data[w_hidx[2]] : w_nxt_data[1];
  end

  // Operand forwarding: later assignments win, so sources are applied from
  // lowest to highest priority (ARF, write stage, queue old->young, retire slot1->3, r0).
  always_comb begin
    for (int o = 0; o < 2; o++) begin
      w_fwd[o] = w_arf_rd[o];
      for (int p = 0; p < 3; p++)
        if (r_wen && (r_waddr[p] == w_rd_addr[o])) w_fwd[o] = r_wdata[p];
      for (int i = 0; i < DEPTH; i++)
        if ((CW'(i) < r_cnt) && (r_q_addr[r_head + PW'(i)] == w_rd_addr[o]))
          w_fwd[o] = r_q_data[r_head + PW'(i)];
      for (int s = 0; s < 3; s++)
        if (w_ret_rdy && w_ret_keep[s] && (w_ret_addr[s] == w_rd_addr[o]))
          w_fwd[o] = w_ret_data[s];
      if (w_rd_addr[o] == '0) w_fwd[o] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_cnt    <= '0;
      r_wen    <= 1'b0;
      r_rd_vld <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_waddr[i] <= '0;
        r_wdata[i] <= '0;
      end
      for (int o = 0; o < 2; o++) r_rd_data[o] <= '0;
    end else begin
      r_head   <= r_head + PW'(w_k);
      r_tail   <= r_tail + PW'(w_enq);
      r_cnt    <= r_cnt + CW'(w_enq) - CW'(w_k);
      r_wen    <= w_sel[0];
      r_rd_vld <= rd_req_valid;
      for (int i = 0; i < 3; i++) begin
        r_waddr[i] <= w_nxt_addr[i];
        r_wdata[i] <= w_nxt_data[i];
      end
      for (int o = 0; o < 2; o++) r_rd_data[o] <= rd_req_valid ? w_fwd[o] : '0;
    end
  end

  // Entry payloads need no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (rstn && w_ret_rdy) begin
      for (int i = 0; i < 3; i++) begin
        if (w_ret_keep[i]) begin
          r_q_addr[r_tail + PW'(w_enq_off[i])] <= w_ret_addr[i];
          r_q_data[r_tail + PW'(w_enq_off[i])] <= w_ret_data[i];
        end
      end
    end
  end

  assign ret_ready       = w_ret_rdy;
  assign arf_write_en    = r_wen;
  assign arf_write_addr1 = r_waddr[0];
  assign arf_write_addr2 = r_waddr[1];
  assign arf_write_addr3 = r_waddr[2];
  assign arf_write_data1 = r_wdata[0];
  assign arf_write_data2 = r_wdata[1];
  assign arf_write_data3 = r_wdata[2];
  assign arf_read_en     = rd_req_valid;
  assign arf_read_addr1  = rd_req_valid ? rd_addr1 : '0;
  assign arf_read_addr2  = rd_req_valid ? rd_addr2 : '0;
  assign rd_resp_valid   = r_rd_vld;
  assign rd_data1        = r_rd_data[0];
  assign rd_data2        = r_rd_data[1];
  assign pending_cnt     = r_cnt;
  assign idle            = (r_cnt == '0) && !r_wen;

endmodule
